score_keeper: RTL and testbench

Upstream scoring stage of the helicopter game. Counts distance points while a run is in progress, stops on collision, and drives the 16-bit binary `score` consumed by the `levels` stage, which compares against exact values 1, 10, 20, 30 and 40. Also keeps a packed-BCD copy for the HEX0–HEX3 score display and an optional high-score register.

---
 rtl/score_keeper.sv | 149 ++++++++++++++
 tb/tb_score_keeper.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - distance score counter with BCD copy and optional high score (SCORE_KEEPER_HISCORE_EN)
module score_keeper #(
    parameter int TICKS_PER_POINT = 8,
    parameter int SCORE_MAX       = 9999
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        start,
    input  logic        collision,
    input  logic        frame_tick,
    output logic [15:0] score,
    output logic [15:0] score_bcd,
    output logic [15:0] high_score,
    output logic        running,
    output logic        game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [7:0]  PRESC_LAST  = 8'(TICKS_PER_POINT - 1);
    localparam logic [15:0] SCORE_LIMIT = 16'(SCORE_MAX);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  presc;
    logic [7:0]  presc_nxt;
    logic [15:0] score_q;
    logic [15:0] score_nxt;
    logic [15:0] bcd_q;
    logic [15:0] bcd_nxt;

    // Four chained decade counters; a digit only advances when all lower digits wrap.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = RUN;
            RUN:     if (collision) state_nxt = OVER;
            OVER:    if (start)     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running   = (state == RUN);
        game_over = (state == OVER);
    end

    // Collision wins over a same-cycle tick so a crash never earns the wrapping point.
    always_comb begin
        presc_nxt = presc;
        score_nxt = score_q;
        bcd_nxt   = bcd_q;
        case (state)
            IDLE: begin
                presc_nxt = 8'd0;
                score_nxt = 16'd0;
                bcd_nxt   = 16'd0;
            end
            RUN: begin
                if (frame_tick && !collision) begin
                    if (presc < PRESC_LAST) begin
                        presc_nxt = presc + 8'd1;
                    end else begin
                        presc_nxt = 8'd0;
                        if (score_q < SCORE_LIMIT) begin
                            score_nxt = score_q + 16'd1;
                            bcd_nxt   = bcd_inc(bcd_q);
                        end
                    end
                end
            end
            OVER: begin
                if (start) begin
                    presc_nxt = 8'd0;
                    score_nxt = 16'd0;
                    bcd_nxt   = 16'd0;
                end
            end
            default: begin
                presc_nxt = 8'd0;
                score_nxt = 16'd0;
                bcd_nxt   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc   <= 8'd0;
            score_q <= 16'd0;
            bcd_q   <= 16'd0;
        end else if (enable) begin
            presc   <= presc_nxt;
            score_q <= score_nxt;
            bcd_q   <= bcd_nxt;
        end
    end

    assign score     = score_q;
    assign score_bcd = bcd_q;

`ifdef SCORE_KEEPER_HISCORE_EN
    logic [15:0] hs_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_q <= 16'd0;
        end else if (enable && state == RUN && collision && score_q > hs_q) begin
            hs_q <= score_q;
        end
    end

    assign high_score = hs_q;
`else
    assign high_score = 16'd0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - table-driven scoreboard bench for score_keeper
module tb_score_keeper;

`ifdef SCORE_KEEPER_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable, start, collision, frame_tick;
    logic [15:0] score, score_bcd, high_score;
    logic        running, game_over;

    logic        f_enable, f_start, f_collision, f_tick;
    logic [15:0] f_score, f_bcd, f_hs;
    logic        f_running, f_over;

    always #5 clk = ~clk;

    score_keeper #(.TICKS_PER_POINT(8), .SCORE_MAX(9999)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .start(start),
        .collision(collision), .frame_tick(frame_tick), .score(score),
        .score_bcd(score_bcd), .high_score(high_score), .running(running),
        .game_over(game_over)
    );

    score_keeper #(.TICKS_PER_POINT(1), .SCORE_MAX(9999)) dut_fast (
        .clk(clk), .resetn(resetn), .enable(f_enable), .start(f_start),
        .collision(f_collision), .frame_tick(f_tick), .score(f_score),
        .score_bcd(f_bcd), .high_score(f_hs), .running(f_running),
        .game_over(f_over)
    );

    typedef struct {
        logic        en, st, col, tick;
        int          cycles;
        logic [15:0] score, bcd, hs;
        logic        run, over;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] score, bcd, hs;
        logic        run, over;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, id, act, exp);
    endtask

    task automatic add(input logic en, input logic st, input logic col, input logic tick, input int cyc,
                       input logic [15:0] s, input logic [15:0] b, input logic [15:0] h,
                       input logic r, input logic o);
        vec_t v;
        v.en = en; v.st = st; v.col = col; v.tick = tick; v.cycles = cyc;
        v.score = s; v.bcd = b; v.hs = HS_EN ? h : 16'd0; v.run = r; v.over = o;
        vt.push_back(v);
    endtask

    task automatic check_outputs(input int id, input logic [15:0] s, input logic [15:0] b,
                                 input logic [15:0] h, input logic r, input logic o);
        chk("score", id, score, s);
        chk("score_bcd", id, score_bcd, b);
        chk("high_score", id, high_score, h);
        chk("running", id, {15'd0, running}, {15'd0, r});
        chk("game_over", id, {15'd0, game_over}, {15'd0, o});
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic drive(input logic en, input logic st, input logic col, input logic tick, input int cyc);
        enable = en; start = st; collision = col; frame_tick = tick;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   bcd_err;

        resetn = 1'b0; enable = 1'b1; start = 1'b0; collision = 1'b0; frame_tick = 1'b0;
        f_enable = 1'b1; f_start = 1'b0; f_collision = 1'b0; f_tick = 1'b0;

        //  en st col tk cyc  score  bcd      hs     run over
        add(1, 0, 1, 1, 5,   0,     16'h0000, 0,     0, 0);
        add(1, 1, 0, 1, 1,   0,     16'h0000, 0,     1, 0);
        add(1, 0, 0, 1, 80,  10,    16'h0010, 0,     1, 0);
        add(1, 0, 0, 1, 72,  19,    16'h0019, 0,     1, 0);
        add(1, 0, 0, 1, 7,   19,    16'h0019, 0,     1, 0);
        add(1, 0, 1, 1, 1,   19,    16'h0019, 19,    0, 1);
        add(1, 0, 0, 1, 16,  19,    16'h0019, 19,    0, 1);
        add(1, 1, 1, 1, 1,   0,     16'h0000, 19,    1, 0);
        add(1, 0, 0, 1, 8,   1,     16'h0001, 19,    1, 0);
        add(0, 1, 1, 1, 50,  1,     16'h0001, 19,    1, 0);
        add(1, 0, 0, 1, 3,   1,     16'h0001, 19,    1, 0);
        add(0, 1, 1, 1, 50,  1,     16'h0001, 19,    1, 0);
        add(1, 0, 0, 1, 4,   1,     16'h0001, 19,    1, 0);
        add(1, 0, 0, 1, 1,   2,     16'h0002, 19,    1, 0);
        add(1, 1, 0, 0, 3,   2,     16'h0002, 19,    1, 0);
        add(1, 0, 0, 1, 184, 25,    16'h0025, 19,    1, 0);
        add(1, 0, 1, 0, 1,   25,    16'h0025, 25,    0, 1);
        add(1, 1, 0, 0, 1,   0,     16'h0000, 25,    1, 0);
        add(1, 0, 0, 1, 96,  12,    16'h0012, 25,    1, 0);
        add(1, 0, 1, 0, 1,   12,    16'h0012, 25,    0, 1);
        add(1, 0, 0, 1, 296, 12,    16'h0012, 25,    0, 1);

        repeat (3) @(posedge clk);
        #1;
        check_outputs(-1, 16'd0, 16'h0000, 16'd0, 1'b0, 1'b0);
        resetn = 1'b1;

        foreach (vt[i]) begin
            e.id = i; e.score = vt[i].score; e.bcd = vt[i].bcd; e.hs = vt[i].hs;
            e.run = vt[i].run; e.over = vt[i].over;
            sb.push_back(e);
            drive(vt[i].en, vt[i].st, vt[i].col, vt[i].tick, vt[i].cycles);
            e = sb.pop_front();
            check_outputs(e.id, e.score, e.bcd, e.hs, e.run, e.over);
        end

        // Reach OVER at 37, then reset asynchronously between edges.
        drive(1, 1, 0, 0, 1);
        drive(1, 0, 0, 1, 296);
        drive(1, 0, 1, 0, 1);
        check_outputs(100, 16'd37, 16'h0037, HS_EN ? 16'd37 : 16'd0, 1'b0, 1'b1);
        drive(1, 0, 0, 0, 0);
        #1 resetn = 1'b0;
        #1;
        check_outputs(101, 16'd0, 16'h0000, 16'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 resetn = 1'b1;
        drive(1, 0, 1, 1, 10);
        check_outputs(102, 16'd0, 16'h0000, 16'd0, 1'b0, 1'b0);

        // One point per tick: BCD carry and saturation at 9999.
        bcd_err = 0;
        f_start = 1'b1;
        @(posedge clk);
        #1;
        f_start = 1'b0;
        f_tick  = 1'b1;
        for (int k = 1; k <= 10019; k++) begin
            @(posedge clk);
            #1;
            if (f_bcd !== to_bcd(int'(f_score))) bcd_err++;
            if (k == 99) begin
                chk("fast_score_99", k, f_score, 16'd99);
                chk("fast_bcd_99", k, f_bcd, 16'h0099);
            end
            if (k == 100) begin
                chk("fast_score_100", k, f_score, 16'd100);
                chk("fast_bcd_100", k, f_bcd, 16'h0100);
            end
        end
        chk("fast_score_sat", 0, f_score, 16'h270F);
        chk("fast_bcd_sat", 0, f_bcd, 16'h9999);
        chk("fast_running", 0, {15'd0, f_running}, 16'd1);
        chk("fast_bcd_track", 0, 16'(bcd_err), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
